// File: rtl/adc_sample_fifo.sv
// Single-clock ADC sample FIFO: first-word-fall-through output, registered fill-level
// status, selectable overflow policy, sticky overflow flag with a saturating drop count.
module adc_sample_fifo #(
    parameter  int DATA_W    = 12,
    parameter  int DEPTH     = 64,
    localparam int AW        = $clog2(DEPTH),
    parameter  int AF_THRESH = 48,
    parameter  int OVF_MODE  = 0,
    parameter  int CNT_W     = 16
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_data_we_valid,
    input  logic [DATA_W-1:0] I_data_we,
    input  logic              I_data_rd_ready,
    output logic              O_data_rd_valid,
    output logic [DATA_W-1:0] O_data_rd,
    output logic [AW:0]       O_level,
    output logic              O_full,
    output logic              O_almost_full,
    output logic              O_overflow,
    output logic [CNT_W-1:0]  O_drop_cnt,
    input  logic              I_flush,
    input  logic              I_clr_status
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, full_q, af_q, ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pop, is_full, do_wr, do_ovw, drop, mem_we;

    // Valid/ready: a sample pops on every cycle where valid and ready are both high;
    // while valid is high and ready low, data and valid hold. Ready alone does nothing.
    assign pop     = valid_q && I_data_rd_ready;
    assign is_full = (level_q == (AW+1)'(DEPTH));
    assign do_wr   = !I_flush && I_data_we_valid && (!is_full || pop);
    assign drop    = !I_flush && I_data_we_valid && is_full && !pop;
    assign do_ovw  = drop && (OVF_MODE != 0);
    assign mem_we  = do_wr || do_ovw;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (I_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (mem_we)         wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop || do_ovw)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + (AW+1)'(do_wr) - (AW+1)'(pop);
        end
    end

    // The head register is loaded with whatever sits at the new read pointer,
    // bypassing the sample being written this cycle when it lands at that slot.
    always_comb begin
        dout_d = dout_q;
        if (level_d != '0) begin
            if (mem_we && (wr_ptr_q == rd_ptr_d)) dout_d = I_data_we;
            else                                  dout_d = mem_q[rd_ptr_d];
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (I_clr_status) begin
            ovf_d = drop;
            cnt_d = drop ? CNT_W'(1) : '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge I_clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= I_data_we;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
            valid_q  <= (level_d != '0);
            full_q   <= (level_d == (AW+1)'(DEPTH));
            af_q     <= (level_d >= (AW+1)'(AF_THRESH));
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign O_data_rd_valid = valid_q;
    assign O_data_rd       = dout_q;
    assign O_level         = level_q;
    assign O_full          = full_q;
    assign O_almost_full   = af_q;
    assign O_overflow      = ovf_q;
    assign O_drop_cnt      = cnt_q;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed bench for adc_sample_fifo: a drop-newest and an overwrite-oldest instance
// share one stimulus stream, and each is checked against hand-computed values.
module tb_adc_sample_fifo;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [11:0] wd;
    logic        rdy;
    logic        flush;
    logic        clr;

    logic        v0, full0, af0, ovf0;
    logic [11:0] d0;
    logic [6:0]  lvl0;
    logic [15:0] cnt0;
    logic        v1, full1, af1, ovf1;
    logic [11:0] d1;
    logic [6:0]  lvl1;
    logic [15:0] cnt1;

    int vectors    = 0;
    int miscompares = 0;

    adc_sample_fifo #(.DATA_W(12), .DEPTH(64), .AF_THRESH(48), .OVF_MODE(0), .CNT_W(16)) u_drop (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_data_we_valid(we), .I_data_we(wd), .I_data_rd_ready(rdy),
        .O_data_rd_valid(v0), .O_data_rd(d0), .O_level(lvl0),
        .O_full(full0), .O_almost_full(af0), .O_overflow(ovf0), .O_drop_cnt(cnt0),
        .I_flush(flush), .I_clr_status(clr)
    );

    adc_sample_fifo #(.DATA_W(12), .DEPTH(64), .AF_THRESH(48), .OVF_MODE(1), .CNT_W(16)) u_ovw (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_data_we_valid(we), .I_data_we(wd), .I_data_rd_ready(rdy),
        .O_data_rd_valid(v1), .O_data_rd(d1), .O_level(lvl1),
        .O_full(full1), .O_almost_full(af1), .O_overflow(ovf1), .O_drop_cnt(cnt1),
        .I_flush(flush), .I_clr_status(clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid0"}, 32'(v0), 32'h0);
        check({tag, " data0"},  32'(d0), 32'h0);
        check({tag, " level0"}, 32'(lvl0), 32'h0);
        check({tag, " full0"},  32'(full0), 32'h0);
        check({tag, " af0"},    32'(af0), 32'h0);
        check({tag, " ovf0"},   32'(ovf0), 32'h0);
        check({tag, " cnt0"},   32'(cnt0), 32'h0);
        check({tag, " valid1"}, 32'(v1), 32'h0);
        check({tag, " level1"}, 32'(lvl1), 32'h0);
        check({tag, " ovf1"},   32'(ovf1), 32'h0);
        check({tag, " cnt1"},   32'(cnt1), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; wd = '0; rdy = 1'b0; flush = 1'b0; clr = 1'b0;
        #2;
        check_zero("reset");
        #10;
        rst_n = 1'b1;
        tick();

        // Streaming with ready high: each sample appears one edge after its write.
        for (int i = 1; i <= 10; i++) begin
            we = 1'b1; rdy = 1'b1; wd = 12'(i);
            tick();
            check("stream data", 32'(d0), 32'(i));
            check("stream valid", 32'(v0), 32'h1);
            check("stream level", 32'(lvl0), 32'h1);
        end
        we = 1'b0;
        tick();
        check("stream drained level", 32'(lvl0), 32'h0);
        check("stream drained valid", 32'(v0), 32'h0);
        check("stream drop cnt", 32'(cnt0), 32'h0);
        rdy = 1'b0;

        // Fill to full with ready low, watching the almost-full and full boundaries.
        for (int i = 0; i < 64; i++) begin
            we = 1'b1; wd = 12'(32'h100 + i);
            tick();
            check("fill level0", 32'(lvl0), 32'(i + 1));
            check("fill level1", 32'(lvl1), 32'(i + 1));
            check("fill head0", 32'(d0), 32'h100);
            if (i == 46) check("af below thresh", 32'(af0), 32'h0);
            if (i == 47) check("af at thresh", 32'(af0), 32'h1);
            if (i == 62) check("full at 63", 32'(full0), 32'h0);
            if (i == 63) begin
                check("full at 64", 32'(full0), 32'h1);
                check("full1 at 64", 32'(full1), 32'h1);
                check("af1 at 64", 32'(af1), 32'h1);
                check("ovf before write", 32'(ovf0), 32'h0);
            end
        end
        wd = 12'h200;
        tick();
        check("drop head0", 32'(d0), 32'h100);
        check("drop level0", 32'(lvl0), 32'd64);
        check("drop ovf0", 32'(ovf0), 32'h1);
        check("drop cnt0", 32'(cnt0), 32'h1);
        check("ovw head1", 32'(d1), 32'h101);
        check("ovw level1", 32'(lvl1), 32'd64);
        check("ovw ovf1", 32'(ovf1), 32'h1);
        check("ovw cnt1", 32'(cnt1), 32'h1);

        we = 1'b0; rdy = 1'b1;
        for (int j = 0; j < 64; j++) begin
            check("drain head0", 32'(d0), 32'h100 + 32'(j));
            check("drain head1", 32'(d1), (j < 63) ? (32'h101 + 32'(j)) : 32'h200);
            check("drain valid1", 32'(v1), 32'h1);
            tick();
        end
        check("drained level0", 32'(lvl0), 32'h0);
        check("drained valid0", 32'(v0), 32'h0);
        check("drained level1", 32'(lvl1), 32'h0);
        check("drained valid1", 32'(v1), 32'h0);
        rdy = 1'b0;

        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr ovf0", 32'(ovf0), 32'h0);
        check("clr cnt0", 32'(cnt0), 32'h0);
        check("clr cnt1", 32'(cnt1), 32'h0);

        // Full FIFO with a simultaneous write and pop: no overflow.
        for (int i = 0; i < 64; i++) begin
            we = 1'b1; wd = 12'(32'h300 + i);
            tick();
        end
        check("refill full", 32'(full0), 32'h1);
        wd = 12'h3FF; rdy = 1'b1;
        tick();
        check("wr+pop level0", 32'(lvl0), 32'd64);
        check("wr+pop ovf0", 32'(ovf0), 32'h0);
        check("wr+pop head0", 32'(d0), 32'h301);
        check("wr+pop level1", 32'(lvl1), 32'd64);
        check("wr+pop ovf1", 32'(ovf1), 32'h0);
        rdy = 1'b0; wd = 12'h3AA;
        tick();
        check("second drop cnt0", 32'(cnt0), 32'h1);
        check("second drop head0", 32'(d0), 32'h301);
        check("second ovw head1", 32'(d1), 32'h302);

        // Flush clears contents but leaves status alone; a write alongside is not a drop.
        we = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush level0", 32'(lvl0), 32'h0);
        check("flush valid0", 32'(v0), 32'h0);
        check("flush keeps cnt0", 32'(cnt0), 32'h1);
        check("flush keeps ovf0", 32'(ovf0), 32'h1);
        for (int i = 0; i < 20; i++) begin
            we = 1'b1; wd = 12'(32'h400 + i);
            tick();
        end
        check("level 20", 32'(lvl0), 32'd20);
        flush = 1'b1; wd = 12'h4FF; rdy = 1'b1;
        tick();
        flush = 1'b0; rdy = 1'b0;
        check("flush+wr level0", 32'(lvl0), 32'h0);
        check("flush+wr valid0", 32'(v0), 32'h0);
        check("flush+wr cnt0", 32'(cnt0), 32'h1);
        check("flush+wr level1", 32'(lvl1), 32'h0);
        wd = 12'h555;
        tick();
        we = 1'b0;
        check("post-flush valid0", 32'(v0), 32'h1);
        check("post-flush data0", 32'(d0), 32'h555);
        check("post-flush level0", 32'(lvl0), 32'h1);
        check("post-flush data1", 32'(d1), 32'h555);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("post-flush drained", 32'(lvl0), 32'h0);

        // Drop counter saturation, then clear coinciding with a drop.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("pre-sat cnt0", 32'(cnt0), 32'h0);
        for (int i = 0; i < 64; i++) begin
            we = 1'b1; wd = 12'(32'h600 + i);
            tick();
        end
        for (int n = 1; n <= 70000; n++) begin
            wd = n[11:0];
            tick();
            if (n == 65534) check("cnt 65534", 32'(cnt0), 32'hFFFE);
            if (n == 65535) check("cnt 65535", 32'(cnt0), 32'hFFFF);
        end
        check("sat cnt0", 32'(cnt0), 32'hFFFF);
        check("sat cnt1", 32'(cnt1), 32'hFFFF);
        check("sat head0", 32'(d0), 32'h600);
        check("sat level0", 32'(lvl0), 32'd64);
        check("sat ovf0", 32'(ovf0), 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr+drop cnt0", 32'(cnt0), 32'h1);
        check("clr+drop ovf0", 32'(ovf0), 32'h1);
        check("clr+drop cnt1", 32'(cnt1), 32'h1);

        // Asynchronous reset in the middle of a write/pop burst.
        rdy = 1'b1;
        repeat (3) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async reset");
        #3;
        rst_n = 1'b1; we = 1'b0; rdy = 1'b0;
        tick();
        check("after reset level0", 32'(lvl0), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
